// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle RV32I subset core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a
// shared memory with a ready handshake, drives datapath strobes and ALU controls,
// and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             alusrc,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             branch,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_IT  = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       opc_q, opc_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic retire_s;
    logic pc_write_s;
    logic ir_write_s;
    logic regwrite_s;
    logic memwrite_s;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_RT, OP_IT, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // State, latched opcode, sticky illegal flag and retired counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opc_q     <= 7'd0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and per-state datapath controls; later states decode opc_q.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        illegal_d  = illegal_q;
        retire_s   = 1'b0;
        pc_write_s = 1'b0;
        pc_src     = 1'b0;
        ir_write_s = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite_s = 1'b0;
        alusrc     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                opc_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                case (opc_q)
                    OP_RT: begin
                        aluop   = 2'b10;
                        state_d = S_WRITEBACK;
                    end
                    OP_IT: begin
                        alusrc  = 1'b1;
                        state_d = S_WRITEBACK;
                    end
                    OP_LW, OP_SW: begin
                        alusrc  = 1'b1;
                        state_d = S_MEMORY;
                    end
                    OP_BEQ: begin
                        aluop      = 2'b01;
                        branch     = 1'b1;
                        pc_src     = 1'b1;
                        pc_write_s = zero;
                        retire_s   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEMORY: begin
                // Address select and ALU controls held steady for the whole wait.
                iord   = 1'b1;
                alusrc = 1'b1;
                case (opc_q)
                    OP_LW: begin
                        memread = 1'b1;
                        if (mem_ready) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_MEMORY;
                        end
                    end
                    OP_SW: begin
                        memwrite_s = 1'b1;
                        if (mem_ready) begin
                            retire_s = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_MEMORY;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_WRITEBACK: begin
                regwrite_s = 1'b1;
                memtoreg   = (opc_q == OP_LW);
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                illegal_d = 1'b1;
                state_d   = S_HALT;
            end
            default: begin
                illegal_d = 1'b1;
                state_d   = S_HALT;
            end
        endcase
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Write-type strobes are gated by reset so they drop immediately on rst.
    assign ir_write = ir_write_s & ~rst;
    assign pc_write = pc_write_s & ~rst;
    assign regwrite = regwrite_s & ~rst;
    assign memwrite = memwrite_s & ~rst;
    assign illegal  = illegal_q;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule
